// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - RV64I execute ALU with valid/ready handshake and iterative shifter.
// Define ALU_BARREL_SHIFT_EN to resolve shifts in the accept cycle instead of iterating.
module alu_multicycle #(
  parameter int XLEN       = 64,
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_funct,
  input  logic            word_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          r_state;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;

  logic [5:0]      w_shamt;
  logic            w_is_shift;
  logic [XLEN-1:0] w_seed;
  logic [XLEN-1:0] w_raw;
  logic [XLEN-1:0] w_res;

  always_comb begin
    w_shamt    = word_op ? {1'b0, operand_b[4:0]} : operand_b[5:0];
    w_is_shift = (alu_funct[1:0] == 2'b01);
    w_seed     = operand_a;
    // Word right shifts must see the 32-bit value extended the way the shift fills.
    if (word_op && alu_funct[2:0] == 3'b101) begin
      if (alu_funct[3]) w_seed = {{(XLEN-32){operand_a[31]}}, operand_a[31:0]};
      else              w_seed = {{(XLEN-32){1'b0}}, operand_a[31:0]};
    end
    w_raw = operand_a;
    case (alu_funct[2:0])
      3'b000: w_raw = alu_funct[3] ? operand_a - operand_b : operand_a + operand_b;
      3'b010: w_raw = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      3'b011: w_raw = {{(XLEN-1){1'b0}}, operand_a < operand_b};
      3'b100: w_raw = operand_a ^ operand_b;
      3'b110: w_raw = operand_a | operand_b;
      3'b111: w_raw = operand_a & operand_b;
`ifdef ALU_BARREL_SHIFT_EN
      3'b001: w_raw = w_seed << w_shamt;
      3'b101: begin
        if (alu_funct[3]) w_raw = $signed(w_seed) >>> w_shamt;
        else              w_raw = w_seed >> w_shamt;
      end
`endif
      default: w_raw = operand_a;
    endcase
    w_res = word_op ? {{(XLEN-32){w_raw[31]}}, w_raw[31:0]} : w_raw;
  end

`ifdef ALU_BARREL_SHIFT_EN
`else
  logic [XLEN-1:0] r_sh;
  logic [6:0]      r_rem;
  logic            r_sll;
  logic            r_sra;
  logic            r_word;
  logic [6:0]      w_step;
  logic [6:0]      w_rem_nxt;
  logic [XLEN-1:0] w_sh_nxt;

  always_comb begin
    w_step    = (r_rem > 7'(SHIFT_STEP)) ? 7'(SHIFT_STEP) : r_rem;
    w_rem_nxt = r_rem - w_step;
    if (r_sll)      w_sh_nxt = r_sh << w_step;
    else if (r_sra) w_sh_nxt = $signed(r_sh) >>> w_step;
    else            w_sh_nxt = r_sh >> w_step;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
`ifdef ALU_BARREL_SHIFT_EN
`else
      r_sh        <= '0;
      r_rem       <= '0;
      r_sll       <= 1'b0;
      r_sra       <= 1'b0;
      r_word      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
`ifdef ALU_BARREL_SHIFT_EN
            r_result    <= w_res;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`else
            r_sh   <= w_seed;
            r_rem  <= {1'b0, w_shamt};
            r_sll  <= (alu_funct[2:0] == 3'b001);
            r_sra  <= alu_funct[3];
            r_word <= word_op;
            if (w_is_shift && w_shamt != 6'd0) begin
              r_state <= S_SHIFT;
            end else begin
              r_result    <= w_res;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
`endif
          end
        end
`ifdef ALU_BARREL_SHIFT_EN
`else
        S_SHIFT: begin
          r_sh  <= w_sh_nxt;
          r_rem <= w_rem_nxt;
          if (w_rem_nxt == 7'd0) begin
            r_result    <= r_word ? {{(XLEN-32){w_sh_nxt[31]}}, w_sh_nxt[31:0]} : w_sh_nxt;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = (r_result == '0);

endmodule
